mac_array_acc: RTL and testbench

- Parametrised successor of the fixed 4-lane MAC wrapper: num lanes of activation x weight multiply, reduced by an adder tree and added to a partial-sum input.
- Fully pipelined with a valid handshake.
- Optional multi-beat accumulation mode: acc_len vectors are summed before a single result is emitted.
- Sits between the activation/weight feeders and the psum path of the PE array.

---
 rtl/mac_array_pkg.sv | 39 +++
 rtl/mac_array_acc_adder_tree.sv | 28 ++
 rtl/mac_array_acc.sv | 163 ++++++++++++++++
 tb/tb_mac_array_acc.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_array_pkg.sv
// Shared types and helpers for the parametrised MAC array with accumulation.
package mac_array_pkg;

    // Default geometry; the top module exposes these as overridable parameters.
    localparam int unsigned default_bw      = 4;
    localparam int unsigned default_psum_bw = 16;
    localparam int unsigned default_num     = 4;
    localparam int unsigned default_acc_len = 4;

    // Widest lane operand the product helper handles; lanes are extended to it.
    localparam int unsigned lane_max = 16;

    // Product width: unsigned activation (made signed with one extra bit) times signed weight.
    localparam int unsigned prod_bw = 2 * lane_max + 1;

    // Beat mode carried down the pipeline.
    typedef enum logic {
        mode_beat = 1'b0,
        mode_acc  = 1'b1
    } mode_e;

    // Width of the beat counter for a given accumulation length.
    function automatic int unsigned cnt_bw(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // One lane product: activation is unsigned (caller zero-extends), weight is
    // signed (caller sign-extends); the activation gains a zero MSB so the
    // multiply is performed fully signed.
    function automatic logic signed [prod_bw-1:0] lane_prod(
        input logic        [lane_max-1:0] a_lane,
        input logic signed [lane_max-1:0] b_lane
    );
        logic signed [lane_max:0] a_signed;
        a_signed = $signed({1'b0, a_lane});
        return a_signed * b_lane;
    endfunction

endpackage

// File: rtl/mac_array_acc_adder_tree.sv
// Combinational binary adder tree; every node wraps modulo 2^in_bw.
module adder_tree #(
    parameter int unsigned num   = 4,
    parameter int unsigned in_bw = 16
) (
    input  logic [num*in_bw-1:0] in_vec,
    output logic [in_bw-1:0]     sum
);

    localparam int unsigned levels = $clog2(num);

    // Level 0 holds the leaves; each following level halves the node count.
    for (genvar l = 0; l <= levels; l++) begin : g_lvl
        logic [in_bw-1:0] node [num >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < num; i++) begin : g_in
                assign node[i] = in_vec[i*in_bw +: in_bw];
            end
        end else begin : g_add
            for (genvar i = 0; i < (num >> l); i++) begin : g_sum
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    assign sum = g_lvl[levels].node[0];

endmodule

// File: rtl/mac_array_acc.sv
// num-lane activation x weight MAC with adder-tree reduction, psum add and
// optional acc_len-beat accumulation. Three-stage pipeline, no backpressure.
module mac_array_acc
    import mac_array_pkg::*;
#(
    parameter int unsigned bw      = default_bw,
    parameter int unsigned psum_bw = default_psum_bw,
    parameter int unsigned num     = default_num,
    parameter int unsigned acc_len = default_acc_len
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic                mode,
    input  logic                clear,
    input  logic [num*bw-1:0]   a,
    input  logic [num*bw-1:0]   b,
    input  logic [psum_bw-1:0]  c,
    output logic [psum_bw-1:0]  out,
    output logic                valid_out,
    output logic                busy
);

    localparam int unsigned cw = cnt_bw(acc_len);
    localparam logic [cw-1:0] cnt_last = cw'(acc_len - 1);
    // With a single-beat accumulation, mode 1 degenerates to mode 0.
    localparam bit single_beat = (acc_len == 1);

    // Stage 1 registers
    logic                s1_valid_r;
    mode_e               s1_mode_r;
    logic [num*bw-1:0]   s1_a_r;
    logic [num*bw-1:0]   s1_b_r;
    logic [psum_bw-1:0]  s1_c_r;

    // Stage 2 registers
    logic                s2_valid_r;
    mode_e               s2_mode_r;
    logic [psum_bw-1:0]  s2_sum_r;
    logic [psum_bw-1:0]  s2_c_r;

    // Stage 3 / accumulator state
    logic [psum_bw-1:0]  acc_r;
    logic [cw-1:0]       cnt_r;
    logic [psum_bw-1:0]  out_r;
    logic                valid_out_r;
    logic                busy_r;

    logic [num*psum_bw-1:0] prod_vec_s;
    logic [psum_bw-1:0]     tree_sum_s;
    logic [psum_bw-1:0]     acc_nxt_s;
    logic [cw-1:0]          cnt_nxt_s;
    logic [psum_bw-1:0]     out_nxt_s;
    logic                   vout_nxt_s;

    // Per-lane products, each sign-extended (or wrapped) to the psum width.
    always_comb begin
        prod_vec_s = '0;
        for (int i = 0; i < num; i++) begin
            prod_vec_s[i*psum_bw +: psum_bw] = psum_bw'(lane_prod(
                lane_max'(s1_a_r[i*bw +: bw]),
                lane_max'($signed(s1_b_r[i*bw +: bw]))));
        end
    end

    adder_tree #(
        .num   (num),
        .in_bw (psum_bw)
    ) u_tree (
        .in_vec (prod_vec_s),
        .sum    (tree_sum_s)
    );

    // Stage-3 decision: emit, start, extend or close an accumulation.
    always_comb begin
        out_nxt_s  = out_r;
        vout_nxt_s = 1'b0;
        if (clear) begin
            acc_nxt_s = '0;
            cnt_nxt_s = '0;
        end else begin
            acc_nxt_s = acc_r;
            cnt_nxt_s = cnt_r;
        end
        if (s2_valid_r) begin
            if ((s2_mode_r == mode_beat) || single_beat) begin
                // Per-beat result; any partial accumulation is abandoned.
                out_nxt_s  = s2_sum_r + s2_c_r;
                vout_nxt_s = 1'b1;
                acc_nxt_s  = '0;
                cnt_nxt_s  = '0;
            end else if (cnt_nxt_s == '0) begin
                // First beat (also after a coincident clear): c enters here only.
                acc_nxt_s = s2_sum_r + s2_c_r;
                cnt_nxt_s = cw'(1);
            end else if (cnt_nxt_s == cnt_last) begin
                out_nxt_s  = acc_r + s2_sum_r;
                vout_nxt_s = 1'b1;
                acc_nxt_s  = '0;
                cnt_nxt_s  = '0;
            end else begin
                acc_nxt_s = acc_r + s2_sum_r;
                cnt_nxt_s = cnt_r + cw'(1);
            end
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Stage 1: capture the incoming beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_mode_r  <= mode_beat;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_c_r     <= '0;
        end else begin
            s1_valid_r <= valid_in;
            s1_mode_r  <= mode_e'(mode);
            s1_a_r     <= a;
            s1_b_r     <= b;
            s1_c_r     <= c;
        end
    end

    // Stage 2: register the reduced lane sum with its partial sum alongside.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid_r <= 1'b0;
            s2_mode_r  <= mode_beat;
            s2_sum_r   <= '0;
            s2_c_r     <= '0;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_mode_r  <= s1_mode_r;
            s2_sum_r   <= tree_sum_s;
            s2_c_r     <= s1_c_r;
        end
    end

    // Stage 3: accumulator, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            out_r       <= '0;
            valid_out_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_r       <= out_nxt_s;
            valid_out_r <= vout_nxt_s;
            busy_r      <= (cnt_nxt_s != '0);
        end
    end

    assign out       = out_r;
    assign valid_out = valid_out_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mac_array_acc.sv
// Scoreboard bench for mac_array_acc at default geometry (4 lanes x 4 bits, psum 16, acc_len 4).
module tb_mac_array_acc;

    localparam int ACCL = 4;

    typedef struct {
        logic [15:0] val;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        mode;
    logic        clear;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] out;
    logic        valid_out;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        out_q[$];
    exp_t        busy_q[$];
    logic [15:0] m_acc;
    int          m_cnt;
    logic [15:0] last_out;
    bit          mon_en = 1'b0;
    logic [1:0]  clr_q;

    always #5 clk = ~clk;

    mac_array_acc #(
        .bw      (4),
        .psum_bw (16),
        .num     (4),
        .acc_len (ACCL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .mode      (mode),
        .clear     (clear),
        .a         (a),
        .b         (b),
        .c         (c),
        .out       (out),
        .valid_out (valid_out),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference lane math: unsigned 4-bit activation times signed 4-bit weight.
    function automatic logic [15:0] model_sum(input logic [15:0] av, input logic [15:0] bv);
        int s;
        int ai;
        int bi;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            ai = int'((av >> (4 * i)) & 16'h000F);
            bi = int'((bv >> (4 * i)) & 16'h000F);
            if (bi > 7) bi = bi - 16;
            s = s + ai * bi;
        end
        return 16'(s);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops expectations when results appear.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            while (busy_q.size() > 0 && busy_q[0].at <= cyc) begin
                e = busy_q.pop_front();
                check_eq("busy", 32'(busy), 32'(e.val));
            end
            if (valid_out === 1'b1) begin
                if (out_q.size() == 0) begin
                    check_eq("spurious_valid", 32'(valid_out), 32'd0);
                end else begin
                    e = out_q.pop_front();
                    check_eq("out", 32'(out), 32'(e.val));
                    check_eq("latency", 32'(cyc), 32'(e.at));
                    last_out = e.val;
                end
            end else begin
                check_eq("out_hold", 32'(out), 32'(last_out));
                if (out_q.size() > 0 && out_q[0].at < cyc) begin
                    e = out_q.pop_front();
                    check_eq("missing_result", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    // Drive one cycle of stimulus and advance the reference model in beat order.
    task automatic step(input logic v, input logic m, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] cv, input logic clr_req);
        logic [15:0] s;
        exp_t        e;
        reset    = 1'b1;
        valid_in = v;
        mode     = m;
        a        = av;
        b        = bv;
        c        = cv;
        clear    = clr_q[1];
        clr_q[1] = clr_q[0];
        clr_q[0] = clr_req;
        if (clr_req) begin
            m_acc = 16'd0;
            m_cnt = 0;
        end
        if (v) begin
            s = model_sum(av, bv);
            if (m == 1'b0 || ACCL == 1) begin
                e.val = s + cv;
                e.at  = cyc + 3;
                out_q.push_back(e);
                m_acc = 16'd0;
                m_cnt = 0;
            end else if (m_cnt == 0) begin
                m_acc = s + cv;
                m_cnt = 1;
            end else if (m_cnt == ACCL - 1) begin
                e.val = m_acc + s;
                e.at  = cyc + 3;
                out_q.push_back(e);
                m_acc = 16'd0;
                m_cnt = 0;
            end else begin
                m_acc = m_acc + s;
                m_cnt = m_cnt + 1;
            end
        end
        e.val = (m_cnt != 0) ? 16'd1 : 16'd0;
        e.at  = cyc + 3;
        busy_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b1;
        mode     = 1'b0;
        clear    = 1'b0;
        a        = 16'h3333;
        b        = 16'h2222;
        c        = 16'd10;
        clr_q    = 2'b00;
        m_acc    = 16'd0;
        m_cnt    = 0;
        last_out = 16'd0;

        // Two reset edges with valid_in held high.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;
        idle(3);

        // Mode 0 basic, then back-to-back beats, then signed and wrap cases.
        step(1'b1, 1'b0, 16'h3333, 16'h2222, 16'd10, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 16'h1234, 16'h5678, 16'd7, 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 16'h7777, 16'h8000, 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 16'h8888, 16'd0, 1'b0);
        step(1'b1, 1'b0, 16'h0001, 16'h0001, 16'hFFFF, 1'b0);
        idle(4);

        // Mode 1 consecutive beats; c counts only on the first beat.
        step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd5, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd99, 1'b0);
        idle(5);

        // Mode 1 with 2-cycle gaps.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'h1111, 16'h1111, (i == 0) ? 16'd5 : 16'd77, 1'b0);
            idle(2);
        end
        idle(4);

        // Mode-0 beat interrupts a partial accumulation.
        step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd3, 1'b0);
        step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd3, 1'b0);
        step(1'b1, 1'b0, 16'h2222, 16'h1111, 16'd1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h2121, 16'h1313, 16'd2, 1'b0);
        idle(5);

        // clear coincident with a mode-1 beat restarts the count at 1.
        step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd40, 1'b0);
        step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd40, 1'b0);
        step(1'b1, 1'b1, 16'h3131, 16'h1111, 16'd6, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd40, 1'b0);
        idle(5);

        // Reset in the middle of an accumulation: nothing emitted, busy drops.
        step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd9, 1'b0);
        step(1'b1, 1'b1, 16'h1111, 16'h1111, 16'd9, 1'b0);
        idle(3);
        mon_en   = 1'b0;
        reset    = 1'b0;
        valid_in = 1'b1;
        mode     = 1'b1;
        @(negedge clk);
        out_q.delete();
        busy_q.delete();
        m_acc    = 16'd0;
        m_cnt    = 0;
        clr_q    = 2'b00;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_valid", 32'(valid_out), 32'd0);
        check_eq("midrst_out", 32'(out), 32'd0);
        last_out = 16'd0;
        mon_en   = 1'b1;
        idle(5);

        // Random mix of modes, bubbles and clears.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 9) == 0));
        end
        idle(6);

        check_eq("queue_drained", 32'(out_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
